// File: rtl/dp_share_pkg.sv
// dp_share_pkg: shared definitions for the datapath-sharing arbiter.
//   - opcode encodings for the shared arithmetic unit (passed through untouched)
//   - tag width helper (index width for NUM_REQ requesters)
//   - one-hot to index encoder used to turn a grant into a tag
package dp_share_pkg;

  typedef logic [1:0] dp_op_t;

  localparam dp_op_t OP_ADD = 2'd0;
  localparam dp_op_t OP_SUB = 2'd1;
  localparam dp_op_t OP_MUL = 2'd2;
  localparam dp_op_t OP_CMP = 2'd3;

  // Largest supported requester count and the matching index width.
  localparam int MAX_REQ   = 8;
  localparam int MAX_TAG_W = 3;

  // Index width for n requesters; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // OR-encoder: input is assumed one-hot (or zero), so no priority is needed.
  function automatic logic [MAX_TAG_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_TAG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx |= MAX_TAG_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant with a rotating priority pointer.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester valid
//   gnt      : combinational one-hot grant (zero when idle or in reset)
// Every grant is a transfer (grant only goes to a valid requester), so the
// pointer moves to one past the granted index whenever gnt is non-zero.
module rr_arbiter
  import dp_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PW = tag_w(NUM_REQ);

  logic [PW-1:0] ptr, ptr_nxt;

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    // Scan from ptr upward, wrapping; first valid requester wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = (idx == NUM_REQ - 1) ? '0 : PW'(idx + 1);
      end
    end
    if (rst) begin
      gnt     = '0;
      ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

endmodule

// File: rtl/dp_share_arbiter.sv
// dp_share_arbiter: shares one fixed-latency datapath unit between NUM_REQ
// requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op  : per-requester operands/opcode, packed by index
//   dp_valid/dp_a/dp_b/dp_op : registered issue to the shared unit
//   dp_result           : unit result, valid LATENCY cycles after dp_valid
//   rsp_valid/rsp_data  : registered one-hot response and its data
//   busy                : any operation still in flight
// The issuing requester's index rides a shift register alongside the unit's
// latency so each result returns to its owner in issue order.
module dp_share_arbiter
  import dp_share_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 64,
  parameter int LATENCY   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]         req_op,
  output logic                         dp_valid,
  output logic [DATAWIDTH-1:0]         dp_a,
  output logic [DATAWIDTH-1:0]         dp_b,
  output dp_op_t                       dp_op,
  input  logic [DATAWIDTH-1:0]         dp_result,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATAWIDTH-1:0]         rsp_data,
  output logic                         busy
);

  localparam int TW = tag_w(NUM_REQ);

  logic [NUM_REQ-1:0]   gnt;
  logic                 xfer;
  logic [TW-1:0]        gnt_idx;
  logic [DATAWIDTH-1:0] sel_a, sel_b;
  dp_op_t               sel_op;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign gnt_idx   = TW'(onehot_to_idx(MAX_REQ'(gnt)));

  // Operand mux: grant is one-hot, so at most one lane contributes.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*DATAWIDTH +: DATAWIDTH];
        sel_b  = req_b[i*DATAWIDTH +: DATAWIDTH];
        sel_op = req_op[i*2 +: 2];
      end
    end
  end

  // Operands hold their last value when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_a  <= '0;
      dp_b  <= '0;
      dp_op <= OP_ADD;
    end else if (xfer) begin
      dp_a  <= sel_a;
      dp_b  <= sel_b;
      dp_op <= sel_op;
    end
  end

  // Stage 0 is the issue stage (dp_valid); stage LATENCY lines up with
  // dp_result for the same operation.
  logic [LATENCY:0]         vld_pipe;
  logic [LATENCY:0][TW-1:0] tag_pipe;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[LATENCY-1:0], xfer};
  end

  // Tags are qualified by vld_pipe, so they need no reset.
  always_ff @(posedge clk) begin
    tag_pipe <= {tag_pipe[LATENCY-1:0], gnt_idx};
  end

  assign dp_valid = vld_pipe[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= vld_pipe[LATENCY] ? (NUM_REQ'(1) << tag_pipe[LATENCY]) : '0;
      if (vld_pipe[LATENCY]) rsp_data <= dp_result;
    end
  end

  assign busy = (|vld_pipe) | (|rsp_valid);

endmodule

// File: tb/tb_dp_share_arbiter.sv
module tb_dp_share_arbiter;
  import dp_share_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic [N*2-1:0]  req_op = '0;
  logic            dp_valid;
  logic [DW-1:0]   dp_a, dp_b, dp_result, rsp_data;
  logic [1:0]      dp_op;
  logic [N-1:0]    rsp_valid;
  logic            busy;

  dp_share_arbiter #(.NUM_REQ(N), .DATAWIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return (a < b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  // Shared unit: result of the operands on the bus appears LAT cycles later.
  logic [DW-1:0] unit_pipe [LAT];
  always @(posedge clk) begin
    unit_pipe[0] <= alu(dp_a, dp_b, dp_op);
    for (int k = 1; k < LAT; k++) unit_pipe[k] <= unit_pipe[k-1];
  end
  assign dp_result = unit_pipe[LAT-1];

  // Reference model state
  typedef struct {
    int            due;
    int            tag;
    logic [DW-1:0] data;
  } exp_rsp_t;

  exp_rsp_t      q[$];
  int            cyc = 0;
  int            ptr = 0;
  bit            rst_cur = 1'b1;
  bit            pend[N];
  logic [DW-1:0] pa[N], pb[N];
  logic [1:0]    pop[N];
  logic          exp_dpv = 1'b0;
  logic [DW-1:0] exp_a = '0, exp_b = '0, exp_rdata = '0;
  logic [1:0]    exp_op = '0;
  int            n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] op);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    pop[i]  = op;
  endtask

  task automatic set_rand(input int i);
    set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(3, 0)));
  endtask

  // One clock: check registered outputs, drive this cycle's inputs, check grant.
  task automatic run_cycle(input bit rst_in);
    logic [N-1:0] exp_rv, exp_gnt;
    logic         exp_busy;
    int           g;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_cur) begin
      q.delete();
      ptr = 0; exp_dpv = 1'b0; exp_a = '0; exp_b = '0; exp_op = '0; exp_rdata = '0;
    end
    chk("dp_valid", 64'(dp_valid), 64'(exp_dpv));
    chk("dp_a", dp_a, exp_a);
    chk("dp_b", dp_b, exp_b);
    chk("dp_op", 64'(dp_op), 64'(exp_op));
    exp_busy = (q.size() != 0);
    exp_rv   = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_rv    = N'(1) << q[0].tag;
      exp_rdata = q[0].data;
      void'(q.pop_front());
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_data", rsp_data, exp_rdata);
    chk("busy", 64'(busy), 64'(exp_busy));

    rst     = rst_in;
    rst_cur = rst_in;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend[i];
      req_a[i*DW +: DW]   = pa[i];
      req_b[i*DW +: DW]   = pb[i];
      req_op[i*2 +: 2]    = pop[i];
    end
    #1;
    g = -1;
    if (!rst_in)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
    exp_gnt = (g < 0) ? '0 : (N'(1) << g);
    chk("req_ready", 64'(req_ready), 64'(exp_gnt));
    exp_dpv = (g >= 0);
    if (g >= 0) begin
      exp_a  = pa[g];
      exp_b  = pb[g];
      exp_op = pop[g];
      q.push_back('{cyc + LAT + 2, g, alu(pa[g], pb[g], pop[g])});
      pend[g] = 1'b0;
      ptr     = (g + 1) % N;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end

    // Reset held with everyone requesting; first grant after release is 0.
    for (int i = 0; i < N; i++) set_rand(i);
    repeat (10) run_cycle(1'b1);
    run_cycle(1'b0);
    chk("first_grant", 64'(req_ready), 64'(4'b0001));
    repeat (8) run_cycle(1'b0);

    // Single ADD from requester 1.
    set_req(1, 64'd5, 64'd7, OP_ADD);
    run_cycle(1'b0);
    repeat (6) run_cycle(1'b0);

    // Fairness from ptr=0 with all four held valid.
    run_cycle(1'b1);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) set_rand(i);
      run_cycle(1'b0);
    end
    repeat (10) run_cycle(1'b0);

    // Pointer skip and wrap: 2, then {0,3} -> 3 then 0, then all -> 1.
    set_rand(2);
    run_cycle(1'b0);
    set_rand(0); set_rand(3);
    run_cycle(1'b0);
    run_cycle(1'b0);
    for (int i = 0; i < N; i++) set_rand(i);
    run_cycle(1'b0);
    chk("ptr_after_wrap", 64'(req_ready), 64'(4'b0010));
    repeat (10) run_cycle(1'b0);

    // Reset while two ops are in flight: nothing may come back.
    set_rand(0); set_rand(1);
    run_cycle(1'b0);
    run_cycle(1'b0);
    run_cycle(1'b1);
    repeat (8) run_cycle(1'b0);

    // Requester 3 streams six ADDs of k+k.
    k = 1;
    while (k <= 6 || pend[3]) begin
      if (!pend[3] && k <= 6) begin
        set_req(3, 64'(k), 64'(k), OP_ADD);
        k++;
      end
      run_cycle(1'b0);
    end
    repeat (6) run_cycle(1'b0);

    // Random traffic with occasional resets.
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1) set_rand(i);
      run_cycle($urandom_range(99, 0) == 0);
    end
    repeat (12) run_cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
